// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-channel writeback FIFOs with round-robin retirement onto
// registered register-file and CSR write ports.
module writeback_arbiter #(
    parameter int N_SRC = 2,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enabled,
    input  logic [N_SRC-1:0]      i_src_valid,
    output logic [N_SRC-1:0]      o_src_ready,
    input  logic [N_SRC*5-1:0]    i_src_rd,
    input  logic [N_SRC*XLEN-1:0] i_src_reg_data,
    input  logic [N_SRC-1:0]      i_src_is_csr,
    input  logic [N_SRC*12-1:0]   i_src_csr_addr,
    input  logic [N_SRC*XLEN-1:0] i_src_csr_data,
    output logic                  o_reg_w_enabled,
    output logic [4:0]            o_reg_w_addr,
    output logic [XLEN-1:0]       o_reg_w_data,
    output logic                  o_csr_w_enabled,
    output logic [11:0]           o_csr_w_addr,
    output logic [XLEN-1:0]       o_csr_w_data,
    output logic                  o_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [RW-1:0] LAST = RW'(N_SRC - 1);

    logic [4:0]      r_rd_mem    [N_SRC][DEPTH];
    logic [XLEN-1:0] r_data_mem  [N_SRC][DEPTH];
    logic            r_csr_mem   [N_SRC][DEPTH];
    logic [11:0]     r_caddr_mem [N_SRC][DEPTH];
    logic [XLEN-1:0] r_cdata_mem [N_SRC][DEPTH];
    logic [PW-1:0]   r_wr_ptr    [N_SRC];
    logic [PW-1:0]   r_rd_ptr    [N_SRC];
    logic [CW-1:0]   r_count     [N_SRC];
    logic [RW-1:0]   r_rr_ptr;

    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_pop;
    logic             w_found;
    logic             w_go;
    logic [RW-1:0]    w_win;
    logic [4:0]       w_head_rd;
    logic [XLEN-1:0]  w_head_data;
    logic             w_head_csr;
    logic [11:0]      w_head_caddr;
    logic [XLEN-1:0]  w_head_cdata;

    function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_SRC) s = s - N_SRC;
        return RW'(s);
    endfunction

    // Null entries (no rd, no CSR) complete the handshake but never occupy a slot.
    always_comb begin
        o_src_ready = '0;
        w_push      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            o_src_ready[i] = !i_rst && (r_count[i] < FULL);
            w_push[i]      = i_src_valid[i] && o_src_ready[i] &&
                             ((i_src_rd[5*i +: 5] != 5'd0) || i_src_is_csr[i]);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!w_found && (r_count[wrap_add(r_rr_ptr, k)] != '0)) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_rr_ptr, k);
            end
        end
        w_go = i_enabled && w_found;
        w_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pop[i] = w_go && (w_win == RW'(i));
        end
        w_head_rd    = r_rd_mem[w_win][r_rd_ptr[w_win]];
        w_head_data  = r_data_mem[w_win][r_rd_ptr[w_win]];
        w_head_csr   = r_csr_mem[w_win][r_rd_ptr[w_win]];
        w_head_caddr = r_caddr_mem[w_win][r_rd_ptr[w_win]];
        w_head_cdata = r_cdata_mem[w_win][r_rd_ptr[w_win]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr        <= '0;
            o_reg_w_enabled <= 1'b0;
            o_reg_w_addr    <= '0;
            o_reg_w_data    <= '0;
            o_csr_w_enabled <= 1'b0;
            o_csr_w_addr    <= '0;
            o_csr_w_data    <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_push[i]) begin
                    r_rd_mem[i][r_wr_ptr[i]]    <= i_src_rd[5*i +: 5];
                    r_data_mem[i][r_wr_ptr[i]]  <= i_src_reg_data[XLEN*i +: XLEN];
                    r_csr_mem[i][r_wr_ptr[i]]   <= i_src_is_csr[i];
                    r_caddr_mem[i][r_wr_ptr[i]] <= i_src_csr_addr[12*i +: 12];
                    r_cdata_mem[i][r_wr_ptr[i]] <= i_src_csr_data[XLEN*i +: XLEN];
                    r_wr_ptr[i]                 <= r_wr_ptr[i] + 1'b1;
                end
                if (w_pop[i]) r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
            if (w_go) r_rr_ptr <= (w_win == LAST) ? '0 : w_win + 1'b1;
            // Address/data are forced to zero whenever their strobe is low.
            o_reg_w_enabled <= w_go && (w_head_rd != 5'd0);
            o_reg_w_addr    <= (w_go && (w_head_rd != 5'd0)) ? w_head_rd : '0;
            o_reg_w_data    <= (w_go && (w_head_rd != 5'd0)) ? w_head_data : '0;
            o_csr_w_enabled <= w_go && w_head_csr;
            o_csr_w_addr    <= (w_go && w_head_csr) ? w_head_caddr : '0;
            o_csr_w_data    <= (w_go && w_head_csr) ? w_head_cdata : '0;
        end
    end

    always_comb begin
        o_busy = o_reg_w_enabled | o_csr_w_enabled;
        for (int i = 0; i < N_SRC; i++) begin
            o_busy = o_busy | (r_count[i] != '0);
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed scoreboard bench for writeback_arbiter.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        enabled;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [9:0]  src_rd;
    logic [63:0] src_reg_data;
    logic [1:0]  src_is_csr;
    logic [23:0] src_csr_addr;
    logic [63:0] src_csr_data;
    logic        reg_w_enabled;
    logic [4:0]  reg_w_addr;
    logic [31:0] reg_w_data;
    logic        csr_w_enabled;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        busy;

    typedef struct {
        logic        reg_en;
        logic [4:0]  ra;
        logic [31:0] rdat;
        logic        csr_en;
        logic [11:0] ca;
        logic [31:0] cdat;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    writeback_arbiter #(.N_SRC(2), .DEPTH(4), .XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_enabled(enabled),
        .i_src_valid(src_valid), .o_src_ready(src_ready),
        .i_src_rd(src_rd), .i_src_reg_data(src_reg_data),
        .i_src_is_csr(src_is_csr), .i_src_csr_addr(src_csr_addr),
        .i_src_csr_data(src_csr_data),
        .o_reg_w_enabled(reg_w_enabled), .o_reg_w_addr(reg_w_addr),
        .o_reg_w_data(reg_w_data), .o_csr_w_enabled(csr_w_enabled),
        .o_csr_w_addr(csr_w_addr), .o_csr_w_data(csr_w_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and matched against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        @(negedge clk);
        if (reg_w_enabled === 1'b1 || csr_w_enabled === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_reg_en",  64'(reg_w_enabled), 64'(e.reg_en));
                check("sb_reg_addr", 64'(reg_w_addr),   64'(e.ra));
                check("sb_reg_data", 64'(reg_w_data),   64'(e.rdat));
                check("sb_csr_en",  64'(csr_w_enabled), 64'(e.csr_en));
                check("sb_csr_addr", 64'(csr_w_addr),   64'(e.ca));
                check("sb_csr_data", 64'(csr_w_data),   64'(e.cdat));
            end
        end else begin
            check("idle_zero", 64'({reg_w_enabled, reg_w_addr, reg_w_data, csr_w_enabled,
                                     csr_w_addr, csr_w_data} != '0), 64'(0));
        end
    endtask

    task automatic clear_src();
        src_valid = '0; src_rd = '0; src_reg_data = '0;
        src_is_csr = '0; src_csr_addr = '0; src_csr_data = '0;
    endtask

    task automatic drive(input int ch, input logic [4:0] rd, input logic [31:0] data,
                         input logic is_csr, input logic [11:0] caddr,
                         input logic [31:0] cdata, input logic expect_write);
        wr_t e;
        src_valid[ch]           = 1'b1;
        src_rd[5*ch +: 5]       = rd;
        src_reg_data[32*ch +: 32] = data;
        src_is_csr[ch]          = is_csr;
        src_csr_addr[12*ch +: 12] = caddr;
        src_csr_data[32*ch +: 32] = cdata;
        if (expect_write) begin
            e.reg_en = (rd != 5'd0);
            e.ra     = (rd != 5'd0) ? rd : 5'd0;
            e.rdat   = (rd != 5'd0) ? data : 32'd0;
            e.csr_en = is_csr;
            e.ca     = is_csr ? caddr : 12'd0;
            e.cdat   = is_csr ? cdata : 32'd0;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enabled = 1'b0; clear_src();
        #1;
        check("rst_ready_low", 64'(src_ready), 64'(0));
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0; enabled = 1'b1;
        #1;
        check("post_rst_ready", 64'(src_ready), 64'(2'b11));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        sb.delete();
        do_reset();

        // 1: single entry, two-cycle latency, busy falls after the write
        drive(0, 5'd5, 32'hDEADBEEF, 1'b0, 12'h0, 32'h0, 1'b1);
        tick();
        clear_src();
        check("t1_no_early_write", 64'(reg_w_enabled), 64'(0));
        check("t1_busy_queued", 64'(busy), 64'(1));
        tick();
        check("t1_write_seen", 64'(reg_w_enabled), 64'(1));
        check("t1_busy_write", 64'(busy), 64'(1));
        tick();
        check("t1_strobe_single", 64'(reg_w_enabled), 64'(0));
        check("t1_busy_fall", 64'(busy), 64'(0));

        // 2: two channels pushing together retire alternately 0,1,0,1,...
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 5'(1 + k), 32'hA000_0000 + 32'(k), 1'b0, 12'h0, 32'h0, 1'b1);
            drive(1, 5'(10 + k), 32'hB000_0000 + 32'(k), 1'b0, 12'h0, 32'h0, 1'b1);
            tick();
        end
        clear_src();
        drain(20);

        // 3: fill channel 0 while stalled, then release
        do_reset();
        enabled = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 5'(20 + k), 32'hC000_0000 + 32'(k), 1'b0, 12'h0, 32'h0, 1'b1);
            tick();
        end
        clear_src();
        check("t3_full_ready", 64'(src_ready[0]), 64'(0));
        check("t3_ch1_ready", 64'(src_ready[1]), 64'(1));
        tick();
        check("t3_stall_busy", 64'(busy), 64'(1));
        enabled = 1'b1;
        tick();
        check("t3_ready_after_pop", 64'(src_ready[0]), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check("t3_consecutive", 64'(reg_w_enabled), 64'(1));
            tick();
        end
        check("t3_last_write", 64'(reg_w_enabled), 64'(1));
        drain(10);
        tick();
        check("t3_idle_busy", 64'(busy), 64'(0));

        // 4: null entry dropped; CSR-only and combined entries
        do_reset();
        drive(0, 5'd0, 32'h1234, 1'b0, 12'h0, 32'h0, 1'b0);
        tick();
        clear_src();
        check("t4_null_not_stored", 64'(busy), 64'(0));
        drive(0, 5'd0, 32'h55, 1'b1, 12'h300, 32'hCAFE, 1'b1);
        tick();
        drive(0, 5'd7, 32'h77, 1'b1, 12'h341, 32'hF00D, 1'b1);
        tick();
        clear_src();
        check("t4_csr_only_strobe", 64'(csr_w_enabled), 64'(1));
        drain(10);
        for (int k = 0; k < 3; k++) tick();

        // 5: queued entries are discarded by reset
        do_reset();
        enabled = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k % 2, 5'(3 + k), 32'hD000_0000 + 32'(k), 1'b0, 12'h0, 32'h0, 1'b0);
            tick();
        end
        clear_src();
        check("t5_busy_before_rst", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", 64'(src_ready), 64'(0));
        tick();
        rst = 1'b0;
        enabled = 1'b1;
        check("t5_busy_after_rst", 64'(busy), 64'(0));
        for (int k = 0; k < 6; k++) tick();
        check("t5_no_writes", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
